// File: rtl/dircc_mem_pkg.sv
// Shared types and helpers for the dircc dual-port node memory.
// Contents:
//   mem_state_e  - sequencer states: idle after reset, clearing, ready for traffic
//   clog2        - elaboration-time ceil(log2) with a floor of 1 bit
//   DFLT_*       - default geometry and the widths derived from it
package dircc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } mem_state_e;

  // Never returns 0: a one-word memory still needs a 1-bit address port.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  localparam int DFLT_DATA_W_A = 32;
  localparam int DFLT_RATIO    = 2;
  localparam int DFLT_DEPTH_A  = 7500;
  localparam int DFLT_DATA_W_B = DFLT_DATA_W_A / DFLT_RATIO;
  localparam int DFLT_ADDR_W_A = clog2(DFLT_DEPTH_A);
  localparam int DFLT_ADDR_W_B = clog2(DFLT_DEPTH_A * DFLT_RATIO);
  localparam int DFLT_BYTES_A  = DFLT_DATA_W_A / 8;
  localparam int DFLT_BYTES_B  = DFLT_DATA_W_B / 8;

endpackage

// File: rtl/dircc_mem_rd_pipe.sv
// Read-return pipeline for one memory port.
// The RAM output register is stage 1; latency 2 adds one more data/valid stage.
// Ports:
//   clk, reset     - clock and asynchronous active-high reset
//   advance        - port enable; when low every stage holds its contents
//   rd_accept      - a read was accepted on this clock edge
//   rd_data_in     - stage-1 read data (RAM output, already range-masked)
//   readdata       - returned data, holds between reads and while stalled
//   readdatavalid  - one flag per accepted read, READ_LATENCY cycles after acceptance
module dircc_mem_rd_pipe #(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              rd_accept,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  logic stage1_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1_valid_reg <= 1'b0;
    end else if (advance) begin
      stage1_valid_reg <= rd_accept;
    end
  end

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic              stage2_valid_reg;
      logic [DATA_W-1:0] stage2_data_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage2_valid_reg <= 1'b0;
          stage2_data_reg  <= '0;
        end else if (advance) begin
          stage2_valid_reg <= stage1_valid_reg;
          // Only real returns overwrite the output, so readdata holds between reads.
          if (stage1_valid_reg) begin
            stage2_data_reg <= rd_data_in;
          end
        end
      end

      assign readdata      = stage2_data_reg;
      assign readdatavalid = stage2_valid_reg;
    end else begin : g_lat1
      // Stage-1 data only changes on an accepted read, so it already holds.
      assign readdata      = rd_data_in;
      assign readdatavalid = stage1_valid_reg;
    end
  endgenerate

endmodule

// File: rtl/dircc_dual_port_mem.sv
// True dual-port node memory with two Avalon-MM slave ports over one byte store.
// Port A (node CPU) is DATA_W_A wide; port B (mailbox/DMA) is DATA_W_A/RATIO wide.
// Port B word b is little-endian lane (b mod RATIO) of port A word b/RATIO.
// A clear sequencer zero-fills (CLEAR_VALUE) one A word per cycle, using the
// port-A write path, after reset (CLEAR_ON_RESET) or on a clear_req pulse.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   reset_req               - stalls both ports and the clear sequencer
//   clear_req / clear_busy  - start the clear sequence / sequence running
//   chipselect, address, byteenable, read, write, writedata, clken,
//   readdata, readdatavalid, waitrequest        - port A
//   chipselect2 ... waitrequest2                - port B
module dircc_dual_port_mem
  import dircc_mem_pkg::*;
#(
  parameter int DATA_W_A       = DFLT_DATA_W_A,
  parameter int RATIO          = DFLT_RATIO,
  parameter int DEPTH_A        = DFLT_DEPTH_A,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CLEAR_VALUE    = 0,
  localparam int DATA_W_B      = DATA_W_A / RATIO,
  localparam int ADDR_W_A      = clog2(DEPTH_A),
  localparam int ADDR_W_B      = clog2(DEPTH_A * RATIO),
  localparam int BYTES_A       = DATA_W_A / 8,
  localparam int BYTES_B       = DATA_W_B / 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic                clear_req,
  output logic                clear_busy,
  input  logic                chipselect,
  input  logic [ADDR_W_A-1:0] address,
  input  logic [BYTES_A-1:0]  byteenable,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W_A-1:0] writedata,
  input  logic                clken,
  output logic [DATA_W_A-1:0] readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  input  logic                chipselect2,
  input  logic [ADDR_W_B-1:0] address2,
  input  logic [BYTES_B-1:0]  byteenable2,
  input  logic                read2,
  input  logic                write2,
  input  logic [DATA_W_B-1:0] writedata2,
  input  logic                clken2,
  output logic [DATA_W_B-1:0] readdata2,
  output logic                readdatavalid2,
  output logic                waitrequest2
);

  localparam int                SUB_W     = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam logic [ADDR_W_A:0] DEPTH_A_L = (ADDR_W_A + 1)'(DEPTH_A);
  localparam logic [ADDR_W_B:0] DEPTH_B_L = (ADDR_W_B + 1)'(DEPTH_A * RATIO);
  localparam logic [ADDR_W_A-1:0] CLR_LAST = ADDR_W_A'(DEPTH_A - 1);
  localparam logic [7:0]        CLR_BYTE  = 8'(CLEAR_VALUE);

  // ---------------------------------------------------------------- sequencer
  mem_state_e          state_reg, state_next;
  logic [ADDR_W_A-1:0] clr_cnt_reg, clr_cnt_next;
  logic                clr_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        state_next   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        clr_cnt_next = '0;
      end
      ST_CLEAR: begin
        // reset_req gates the memory clock enable, so the sweep pauses too.
        if (!reset_req) begin
          if (clr_cnt_reg == CLR_LAST) begin
            state_next = ST_READY;
          end else begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
          end
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign clr_we     = (state_reg == ST_CLEAR) & ~reset_req;
  assign clear_busy = (state_reg == ST_CLEAR) |
                      ((state_reg == ST_IDLE) & (CLEAR_ON_RESET != 0));

  // ---------------------------------------------------------------- handshake
  logic adv_a, adv_b;
  logic a_rd_acc, a_wr_acc, b_rd_acc, b_wr_acc;
  logic a_in_range, b_in_range;
  logic [ADDR_W_A-1:0] b_word;
  logic [SUB_W-1:0]    b_sub;
  logic [ADDR_W_A-1:0] a_wr_idx;

  assign adv_a        = clken  & ~reset_req;
  assign adv_b        = clken2 & ~reset_req;
  assign waitrequest  = (state_reg != ST_READY) | ~adv_a;
  assign waitrequest2 = (state_reg != ST_READY) | ~adv_b;

  assign a_in_range = {1'b0, address}  < DEPTH_A_L;
  assign b_in_range = {1'b0, address2} < DEPTH_B_L;

  // A command carrying both read and write is treated as a write only.
  assign a_rd_acc = chipselect  & read  & ~write  & ~waitrequest;
  assign b_rd_acc = chipselect2 & read2 & ~write2 & ~waitrequest2;
  assign a_wr_acc = chipselect  & write  & ~waitrequest  & a_in_range;
  assign b_wr_acc = chipselect2 & write2 & ~waitrequest2 & b_in_range;

  assign b_word   = ADDR_W_A'(address2 / RATIO);
  assign b_sub    = SUB_W'(address2 % RATIO);
  assign a_wr_idx = clr_we ? clr_cnt_reg : address;

  // ---------------------------------------------------------------- storage
  logic [DATA_W_A-1:0] a_q_all, b_q_all;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_A; gi++) begin : g_lane
      localparam int B_SUB  = gi / BYTES_B;
      localparam int B_BYTE = gi % BYTES_B;

      logic [7:0] lane_mem [DEPTH_A];
      logic [7:0] a_q_reg, b_q_reg;
      logic       a_we, b_we;
      logic [7:0] a_wd, b_wd;

      assign a_we = clr_we | (a_wr_acc & byteenable[gi]);
      assign a_wd = clr_we ? CLR_BYTE : writedata[8*gi +: 8];
      assign b_we = b_wr_acc & (b_sub == SUB_W'(B_SUB)) & byteenable2[B_BYTE];
      assign b_wd = writedata2[8*B_BYTE +: 8];

      // Port A write is issued after port B so it wins a same-byte collision.
      // Reads sample the array before this edge's writes land: old data.
      always_ff @(posedge clk) begin
        if (b_we) begin
          lane_mem[b_word] <= b_wd;
        end
        if (a_we) begin
          lane_mem[a_wr_idx] <= a_wd;
        end
        if (a_rd_acc) begin
          a_q_reg <= lane_mem[address];
        end
        if (b_rd_acc) begin
          b_q_reg <= lane_mem[b_word];
        end
      end

      assign a_q_all[8*gi +: 8] = a_q_reg;
      assign b_q_all[8*gi +: 8] = b_q_reg;
    end
  endgenerate

  // Per-read side information travelling alongside the RAM output register.
  // Clearing the range flags on reset also forces readdata to zero.
  logic             a_rng_reg, b_rng_reg;
  logic [SUB_W-1:0] b_sub_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rng_reg <= 1'b0;
      b_rng_reg <= 1'b0;
      b_sub_reg <= '0;
    end else begin
      if (a_rd_acc) begin
        a_rng_reg <= a_in_range;
      end
      if (b_rd_acc) begin
        b_rng_reg <= b_in_range;
        b_sub_reg <= b_sub;
      end
    end
  end

  logic [DATA_W_A-1:0] a_data_in;
  logic [DATA_W_B-1:0] b_data_in;

  assign a_data_in = a_rng_reg ? a_q_all : '0;
  assign b_data_in = b_rng_reg ? b_q_all[DATA_W_B*b_sub_reg +: DATA_W_B] : '0;

  dircc_mem_rd_pipe #(
    .DATA_W       (DATA_W_A),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe_a (
    .clk           (clk),
    .reset         (reset),
    .advance       (adv_a),
    .rd_accept     (a_rd_acc),
    .rd_data_in    (a_data_in),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  dircc_mem_rd_pipe #(
    .DATA_W       (DATA_W_B),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe_b (
    .clk           (clk),
    .reset         (reset),
    .advance       (adv_b),
    .rd_accept     (b_rd_acc),
    .rd_data_in    (b_data_in),
    .readdata      (readdata2),
    .readdatavalid (readdatavalid2)
  );

endmodule

// File: tb/tb_dircc_dual_port_mem.sv
// Bench for dircc_dual_port_mem: directed scenarios plus a randomized run,
// all checked cycle by cycle against a byte-array model with read queues.
module tb_dircc_dual_port_mem;

  localparam int DW_A    = 32;
  localparam int RATIO   = 2;
  localparam int DEPTH_A = 12;    // not a power of two, so out-of-range addresses exist
  localparam int DEPTH_B = DEPTH_A * RATIO;
  localparam int LAT     = 2;
  localparam int CLR_ON  = 1;
  localparam logic [7:0] CLR_VAL = 8'h00;

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_READY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_req = 1'b0, clear_req = 1'b0;
  logic        clear_busy;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0, clken = 1'b1;
  logic [3:0]  address = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid, waitrequest;
  logic        chipselect2 = 1'b0, read2 = 1'b0, write2 = 1'b0, clken2 = 1'b1;
  logic [4:0]  address2 = '0;
  logic [1:0]  byteenable2 = '0;
  logic [15:0] writedata2 = '0;
  logic [15:0] readdata2;
  logic        readdatavalid2, waitrequest2;

  always #5 clk = ~clk;

  dircc_dual_port_mem #(
    .DATA_W_A       (DW_A),
    .RATIO          (RATIO),
    .DEPTH_A        (DEPTH_A),
    .READ_LATENCY   (LAT),
    .CLEAR_ON_RESET (CLR_ON),
    .CLEAR_VALUE    (0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .reset_req      (reset_req),
    .clear_req      (clear_req),
    .clear_busy     (clear_busy),
    .chipselect     (chipselect),
    .address        (address),
    .byteenable     (byteenable),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .clken          (clken),
    .readdata       (readdata),
    .readdatavalid  (readdatavalid),
    .waitrequest    (waitrequest),
    .chipselect2    (chipselect2),
    .address2       (address2),
    .byteenable2    (byteenable2),
    .read2          (read2),
    .write2         (write2),
    .writedata2     (writedata2),
    .clken2         (clken2),
    .readdata2      (readdata2),
    .readdatavalid2 (readdatavalid2),
    .waitrequest2   (waitrequest2)
  );

  // ------------------------------------------------------------ model state
  typedef struct {
    logic [31:0] data;
    int          age;
  } rd_t;

  logic [7:0] mem_m [DEPTH_A*4];
  rd_t        qa[$];
  rd_t        qb[$];
  int         m_state;
  int         clr_idx;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        got_a, got_b;
  logic [31:0] got_a_data;
  logic [15:0] got_b_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cmds();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0;
    clear_req = 1'b0;
  endtask

  // One clock with the currently driven inputs; the model is advanced and every
  // observable output compared just after the edge.
  task automatic step();
    bit          ready = (m_state == M_READY);
    bit          adv_a = clken  && !reset_req;
    bit          adv_b = clken2 && !reset_req;
    bit          acc_a = ready && adv_a && chipselect  && (read  || write);
    bit          acc_b = ready && adv_b && chipselect2 && (read2 || write2);
    bit          rd_a  = acc_a && read  && !write;
    bit          rd_b  = acc_b && read2 && !write2;
    bit          wr_a  = acc_a && write;
    bit          wr_b  = acc_b && write2;
    bit          exp_v;
    bit          exp_busy;
    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    int          ia = int'(address);
    int          ib = int'(address2);

    if (rd_a && ia < DEPTH_A) for (int k = 0; k < 4; k++) exp_a[8*k +: 8] = mem_m[ia*4 + k];
    if (rd_b && ib < DEPTH_B) for (int k = 0; k < 2; k++) exp_b[8*k +: 8] = mem_m[ib*2 + k];

    @(posedge clk);
    #1;

    if (adv_a) foreach (qa[i]) qa[i].age = qa[i].age + 1;
    if (adv_b) foreach (qb[i]) qb[i].age = qb[i].age + 1;
    if (rd_a) qa.push_back('{exp_a, 1});
    if (rd_b) qb.push_back('{exp_b, 1});

    // Port B first so that port A overrides a shared byte.
    if (wr_b && ib < DEPTH_B)
      for (int k = 0; k < 2; k++) if (byteenable2[k]) mem_m[ib*2 + k] = writedata2[8*k +: 8];
    if (wr_a && ia < DEPTH_A)
      for (int k = 0; k < 4; k++) if (byteenable[k]) mem_m[ia*4 + k] = writedata[8*k +: 8];

    if (m_state == M_IDLE) begin
      m_state = CLR_ON ? M_CLEAR : M_READY;
      clr_idx = 0;
    end else if (m_state == M_CLEAR) begin
      if (!reset_req) begin
        for (int k = 0; k < 4; k++) mem_m[clr_idx*4 + k] = CLR_VAL;
        clr_idx++;
        if (clr_idx == DEPTH_A) m_state = M_READY;
      end
    end else if (clear_req) begin
      m_state = M_CLEAR;
      clr_idx = 0;
    end

    if (adv_a) begin
      exp_v = (qa.size() > 0) && (qa[0].age == LAT);
      check_eq("rdvalid_a", 32'(readdatavalid), 32'(exp_v));
      if (readdatavalid) begin
        got_a = 1'b1;
        got_a_data = readdata;
      end
      if (exp_v) begin
        check_eq("rdata_a", readdata, qa[0].data);
        void'(qa.pop_front());
      end
    end
    if (adv_b) begin
      exp_v = (qb.size() > 0) && (qb[0].age == LAT);
      check_eq("rdvalid_b", 32'(readdatavalid2), 32'(exp_v));
      if (readdatavalid2) begin
        got_b = 1'b1;
        got_b_data = readdata2;
      end
      if (exp_v) begin
        check_eq("rdata_b", 32'(readdata2), 32'(qb[0].data[15:0]));
        void'(qb.pop_front());
      end
    end

    exp_busy = (m_state == M_CLEAR) || (m_state == M_IDLE && CLR_ON != 0);
    check_eq("clear_busy", 32'(clear_busy), 32'(exp_busy));
    check_eq("waitreq_a", 32'(waitrequest),  32'((m_state != M_READY) || !adv_a));
    check_eq("waitreq_b", 32'(waitrequest2), 32'((m_state != M_READY) || !adv_b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_cmds();
    reset_req = 1'b0; clken = 1'b1; clken2 = 1'b1;
    #1;
    check_eq("rst_rdvalid_a", 32'(readdatavalid), 32'd0);
    check_eq("rst_rdvalid_b", 32'(readdatavalid2), 32'd0);
    check_eq("rst_rdata_a", readdata, 32'd0);
    check_eq("rst_rdata_b", 32'(readdata2), 32'd0);
    check_eq("rst_waitreq_a", 32'(waitrequest), 32'd1);
    check_eq("rst_waitreq_b", 32'(waitrequest2), 32'd1);
    check_eq("rst_clear_busy", 32'(clear_busy), 32'(CLR_ON));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_state = M_IDLE;
    clr_idx = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic count_clear(output int n);
    n = 0;
    for (int i = 0; i < 4*DEPTH_A + 8; i++) begin
      step();
      if (!clear_busy) break;
      n++;
    end
  endtask

  task automatic wait_a(output logic [31:0] d);
    for (int i = 0; i < 16 && !got_a; i++) step();
    if (!got_a) check_eq("timeout_a", 32'd0, 32'd1);
    d = got_a_data;
  endtask

  task automatic wait_b(output logic [15:0] d);
    for (int i = 0; i < 16 && !got_b; i++) step();
    if (!got_b) check_eq("timeout_b", 32'd0, 32'd1);
    d = got_b_data;
  endtask

  task automatic read_a(input logic [3:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    got_a = 1'b0;
    step();
    chipselect = 1'b0; read = 1'b0;
    wait_a(d);
  endtask

  task automatic read_b(input logic [4:0] a, output logic [15:0] d);
    chipselect2 = 1'b1; read2 = 1'b1; write2 = 1'b0; address2 = a;
    got_b = 1'b0;
    step();
    chipselect2 = 1'b0; read2 = 1'b0;
    wait_b(d);
  endtask

  task automatic write_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d; byteenable = be;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    int          nbusy;
    logic [31:0] da;
    logic [31:0] held;
    logic [15:0] db;

    for (int i = 0; i < DEPTH_A*4; i++) mem_m[i] = 8'h00;
    m_state = M_IDLE;
    clr_idx = 0;
    got_a = 1'b0;
    got_b = 1'b0;
    got_a_data = '0;
    got_b_data = '0;

    // 1: clear after reset takes one cycle per A word, then the ports open.
    do_reset();
    count_clear(nbusy);
    check_eq("clear_cycles", nbusy, DEPTH_A);
    check_eq("ready_waitreq", 32'(waitrequest), 32'd0);
    read_a(4'd5, da);
    check_eq("t1_read_a5", da, 32'h0);

    // 2: wide write, narrow little-endian reads.
    write_a(4'd3, 32'hDEADBEEF, 4'hF);
    read_b(5'd6, db);
    check_eq("t2_b6", 32'(db), 32'h0000BEEF);
    read_b(5'd7, db);
    check_eq("t2_b7", 32'(db), 32'h0000DEAD);

    // 3: colliding writes on the same bytes, port A wins.
    chipselect = 1'b1; write = 1'b1; address = 4'd2; writedata = 32'h11223344; byteenable = 4'h3;
    chipselect2 = 1'b1; write2 = 1'b1; address2 = 5'd4; writedata2 = 16'hAAAA; byteenable2 = 2'h3;
    step();
    idle_cmds();
    read_a(4'd2, da);
    check_eq("t3_a_wins", da, 32'h00003344);

    // 4: B reads the word A is writing in the same cycle and sees old data.
    chipselect = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'hCAFEF00D; byteenable = 4'hF;
    chipselect2 = 1'b1; read2 = 1'b1; address2 = 5'd2;
    got_b = 1'b0;
    step();
    idle_cmds();
    wait_b(db);
    check_eq("t4_old_data", 32'(db), 32'h0);
    read_b(5'd2, db);
    check_eq("t4_new_data", 32'(db), 32'h0000F00D);

    // 5: stalling port A holds the read pipeline.
    chipselect = 1'b1; read = 1'b1; address = 4'd3;
    got_a = 1'b0;
    step();
    idle_cmds();
    held = readdata;
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5_stall_valid", 32'(readdatavalid), 32'd0);
      check_eq("t5_stall_data", readdata, held);
    end
    clken = 1'b1;
    wait_a(da);
    check_eq("t5_data", da, 32'hDEADBEEF);

    // 6: read in flight at clear entry, then reset part way through the clear.
    write_a(4'd3, 32'h12345678, 4'hF);
    chipselect = 1'b1; read = 1'b1; address = 4'd3; clear_req = 1'b1;
    got_a = 1'b0;
    step();
    idle_cmds();
    wait_a(da);
    check_eq("t6_inflight", da, 32'h12345678);
    repeat (3) step();
    do_reset();
    count_clear(nbusy);
    check_eq("t6_clear_restart", nbusy, DEPTH_A);
    read_a(4'd3, da);
    check_eq("t6_cleared_a3", da, 32'h0);
    read_b(5'd3, db);
    check_eq("t6_cleared_b3", 32'(db), 32'h0);

    // Randomized traffic on both ports, including out-of-range addresses,
    // stalls, reset_req, clear requests and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      chipselect  = ($urandom_range(0, 3) != 0);
      read        = 1'($urandom_range(0, 1));
      write       = 1'($urandom_range(0, 1));
      address     = 4'($urandom_range(0, 15));
      byteenable  = 4'($urandom);
      writedata   = $urandom;
      chipselect2 = ($urandom_range(0, 3) != 0);
      read2       = 1'($urandom_range(0, 1));
      write2      = 1'($urandom_range(0, 1));
      address2    = 5'($urandom_range(0, 31));
      byteenable2 = 2'($urandom);
      writedata2  = 16'($urandom);
      clken       = ($urandom_range(0, 7) != 0);
      clken2      = ($urandom_range(0, 7) != 0);
      reset_req   = ($urandom_range(0, 31) == 0);
      clear_req   = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
